// File: rtl/seg_scan_ctrl_if.sv
// Load handshake bundle for seg_scan_ctrl: a new display value plus its decimal points.
interface seg_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_dp;

    modport master (
        output load_valid,
        output load_data,
        output load_dp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_dp,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a pending/active value pipeline.
// Leading-zero blanking is compiled in only when LEADING_ZERO_BLANK_EN is defined.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    seg_scan_ctrl_if.slave load,
    output logic [1:0]     digit_sel,
    output logic [6:0]     seg,
    output logic           dp,
    output logic           frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nx_s;
    logic [1:0]    digit_r;
    logic [1:0]    digit_nx_s;
    logic [6:0]    seg_r;
    logic [6:0]    seg_nx_s;
    logic          dp_r;
    logic          dp_nx_s;
    logic          frame_done_r;
    logic          frame_done_nx_s;

    logic [15:0]   pend_value_r;
    logic [3:0]    pend_dp_r;
    logic          pend_valid_r;
    logic [15:0]   act_value_r;
    logic [3:0]    act_dp_r;
    logic [15:0]   act_value_nx_s;
    logic [3:0]    act_dp_nx_s;

    logic          tick_s;
    logic          boundary_s;
    logic          xfer_s;
    logic          promote_s;
    logic [3:0]    nibble_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [15:0] v, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = v[3:0];
            2'd1:    nib = v[7:4];
            2'd2:    nib = v[11:8];
            2'd3:    nib = v[15:12];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit to its left are zero with no lit point.
    function automatic logic lead_blank(input logic [15:0] v, input logic [3:0] dpv,
                                        input logic [1:0] idx);
        logic blank;
        case (idx)
            2'd1:    blank = (v[15:4]  == 12'h000) && !dpv[1];
            2'd2:    blank = (v[15:8]  == 8'h00)   && !dpv[2];
            2'd3:    blank = (v[15:12] == 4'h0)    && !dpv[3];
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: enable alone decides between OFF and SCAN
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (enable) state_nx_s = ST_SCAN;
                else        state_nx_s = ST_OFF;
            end
            ST_SCAN: begin
                if (enable) state_nx_s = ST_SCAN;
                else        state_nx_s = ST_OFF;
            end
            default: state_nx_s = ST_OFF;
        endcase
    end

    // Tick, frame boundary, handshake transfer and pending-to-active promotion
    always_comb begin
        tick_s     = 1'b0;
        boundary_s = 1'b0;
        xfer_s     = 1'b0;
        promote_s  = 1'b0;
        if ((state_r == ST_SCAN) && enable) begin
            tick_s = (presc_r == PRESC_LAST);
        end else begin
            tick_s = 1'b0;
        end
        boundary_s = tick_s && (digit_r == 2'd3);
        xfer_s     = load.load_valid && !pend_valid_r;
        if (pend_valid_r && ((state_r == ST_OFF) || boundary_s)) begin
            promote_s = 1'b1;
        end else begin
            promote_s = 1'b0;
        end
    end

    // Prescaler and digit index; both restart from zero whenever SCAN is (re)entered
    always_comb begin
        presc_nx_s = '0;
        digit_nx_s = 2'd0;
        if ((state_r == ST_SCAN) && (state_nx_s == ST_SCAN)) begin
            if (tick_s) begin
                presc_nx_s = '0;
                digit_nx_s = digit_r + 2'd1;
            end else begin
                presc_nx_s = presc_r + PW'(1);
                digit_nx_s = digit_r;
            end
        end else begin
            presc_nx_s = '0;
            digit_nx_s = 2'd0;
        end
    end

    // Display outputs are decoded from next-cycle digit and value so they change together
    always_comb begin
        act_value_nx_s  = act_value_r;
        act_dp_nx_s     = act_dp_r;
        nibble_s        = 4'h0;
        seg_nx_s        = 7'h7F;
        dp_nx_s         = 1'b1;
        frame_done_nx_s = 1'b0;
        if (promote_s) begin
            act_value_nx_s = pend_value_r;
            act_dp_nx_s    = pend_dp_r;
        end else begin
            act_value_nx_s = act_value_r;
            act_dp_nx_s    = act_dp_r;
        end
        nibble_s = nibble_at(act_value_nx_s, digit_nx_s);
        if (state_nx_s == ST_SCAN) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (lead_blank(act_value_nx_s, act_dp_nx_s, digit_nx_s)) begin
                seg_nx_s = 7'h7F;
            end else begin
                seg_nx_s = hex_to_seg(nibble_s);
            end
`else
            seg_nx_s = hex_to_seg(nibble_s);
`endif
            dp_nx_s         = ~act_dp_nx_s[digit_nx_s];
            frame_done_nx_s = boundary_s;
        end else begin
            seg_nx_s        = 7'h7F;
            dp_nx_s         = 1'b1;
            frame_done_nx_s = 1'b0;
        end
    end

    // Scan counters and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r      <= '0;
            digit_r      <= 2'd0;
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            presc_r      <= presc_nx_s;
            digit_r      <= digit_nx_s;
            seg_r        <= seg_nx_s;
            dp_r         <= dp_nx_s;
            frame_done_r <= frame_done_nx_s;
        end
    end

    // Pending and active value registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value_r <= 16'h0000;
            pend_dp_r    <= 4'b0000;
            pend_valid_r <= 1'b0;
            act_value_r  <= 16'h0000;
            act_dp_r     <= 4'b0000;
        end else begin
            if (xfer_s) begin
                pend_value_r <= load.load_data;
                pend_dp_r    <= load.load_dp;
                pend_valid_r <= 1'b1;
            end else if (promote_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
            act_value_r <= act_value_nx_s;
            act_dp_r    <= act_dp_nx_s;
        end
    end

    assign load.load_ready = ~pend_valid_r;
    assign digit_sel       = digit_r;
    assign seg             = seg_r;
    assign dp              = dp_r;
    assign frame_done      = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with REFRESH_DIV=4 (16 cycles per frame).
module tb_seg_scan_ctrl;

    localparam int DIV = 4;
    localparam logic [6:0] S_BLANK = 7'h7F;
    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_3 = 7'b0110000;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_7 = 7'b1111000;
    localparam logic [6:0] S_8 = 7'b0000000;
    localparam logic [6:0] S_9 = 7'b0010000;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_F = 7'b0001110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] digit_sel;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;
    int         checks = 0;
    int         failures = 0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (bus),
        .digit_sel  (digit_sel),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge where frame_done is seen high (frame position p=0).
    task automatic wait_frame();
        bit found = 1'b0;
        for (int i = 0; i < 48 && !found; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_sync: frame_done stayed 0, required 1 within 48 cycles");
        end
    endtask

    task automatic test_reset();
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0000;
        bus.load_dp    = 4'b0000;
        enable = 1'b0;
        rst_n  = 1'b0;
        #12;
        checks++; if (digit_sel !== 2'd0) begin failures++; $display("FAIL reset_digit: got %0d required 0", digit_sel); end
        checks++; if (seg !== S_BLANK) begin failures++; $display("FAIL reset_seg: got %h required 7f", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b required 1", dp); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd: got %b required 0", frame_done); end
        checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", bus.load_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (seg !== S_BLANK || digit_sel !== 2'd0) begin failures++; $display("FAIL off_hold: seg %h digit %0d required 7f/0", seg, digit_sel); end
    endtask

    task automatic test_scan_zero();
        enable = 1'b1;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            checks++; if (digit_sel !== 2'((k / 4) % 4)) begin failures++; $display("FAIL scan_digit k=%0d: got %0d required %0d", k, digit_sel, (k / 4) % 4); end
            checks++; if (seg !== S_0 || dp !== 1'b1) begin failures++; $display("FAIL scan_seg k=%0d: got %h/%b required 40/1", k, seg, dp); end
            checks++; if (frame_done !== (k == 16)) begin failures++; $display("FAIL scan_fd k=%0d: got %b required %b", k, frame_done, (k == 16)); end
        end
    endtask

    // Offers one value at frame position load_at, then checks the following frame digit by digit.
    task automatic test_load(input logic [15:0] data, input logic [3:0] dpv, input int load_at,
                             input logic [3:0][6:0] exp_seg, input logic [3:0] exp_dp);
        wait_frame();
        for (int p = 0; p < 32; p++) begin
            if (p > 0) @(negedge clk);
            if (p == load_at) begin
                checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL load_ready_idle p=%0d: got %b required 1", p, bus.load_ready); end
            end
            if (p > load_at && p < 16) begin
                checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL load_ready_busy p=%0d: got %b required 0", p, bus.load_ready); end
            end
            if (p > 0) begin
                checks++; if (frame_done !== (p == 16)) begin failures++; $display("FAIL load_fd p=%0d: got %b required %b", p, frame_done, (p == 16)); end
            end
            if (p == 16) begin
                checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL load_ready_free: got %b required 1", bus.load_ready); end
            end
            if (p >= 16) begin
                checks++; if (digit_sel !== 2'((p - 16) / 4)) begin failures++; $display("FAIL load_digit p=%0d: got %0d required %0d", p, digit_sel, (p - 16) / 4); end
                checks++; if (seg !== exp_seg[(p - 16) / 4]) begin failures++; $display("FAIL load_seg %h p=%0d: got %h required %h", data, p, seg, exp_seg[(p - 16) / 4]); end
                checks++; if (dp !== exp_dp[(p - 16) / 4]) begin failures++; $display("FAIL load_dp %h p=%0d: got %b required %b", data, p, dp, exp_dp[(p - 16) / 4]); end
            end
            if (p == load_at) begin
                bus.load_valid = 1'b1;
                bus.load_data  = data;
                bus.load_dp    = dpv;
            end else if (p == load_at + 1) begin
                bus.load_valid = 1'b0;
                bus.load_data  = 16'hDEAD;
            end
        end
    endtask

    task automatic test_stream();
        logic [6:0] frame_seg [3];
        frame_seg[0] = S_1;
        frame_seg[1] = S_3;
        frame_seg[2] = S_5;
        wait_frame();
        for (int p = 0; p <= 48; p++) begin
            if (p > 0) @(negedge clk);
            checks++; if (bus.load_ready !== (p % 16 == 0)) begin failures++; $display("FAIL stream_ready p=%0d: got %b required %b", p, bus.load_ready, (p % 16 == 0)); end
            if (p > 0) begin
                checks++; if (frame_done !== (p % 16 == 0)) begin failures++; $display("FAIL stream_fd p=%0d: got %b required %b", p, frame_done, (p % 16 == 0)); end
            end
            if (p >= 16) begin
                checks++; if (seg !== frame_seg[p / 16 - 1] || dp !== 1'b1) begin failures++; $display("FAIL stream_seg p=%0d: got %h/%b required %h/1", p, seg, dp, frame_seg[p / 16 - 1]); end
            end
            bus.load_valid = (p != 48);
            bus.load_data  = 16'(16'h1111 * (p % 7 + 1));
            bus.load_dp    = 4'b0000;
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic test_boundary_xfer();
        wait_frame();
        for (int p = 0; p <= 32; p++) begin
            if (p > 0) @(negedge clk);
            if (p == 15) begin
                checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL bx_ready_pre: got %b required 1", bus.load_ready); end
            end
            if (p == 16) begin
                checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL bx_fd: got %b required 1", frame_done); end
            end
            if (p >= 16 && p < 32) begin
                checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL bx_ready_busy p=%0d: got %b required 0", p, bus.load_ready); end
                checks++; if (seg !== S_5) begin failures++; $display("FAIL bx_seg_old p=%0d: got %h required %h", p, seg, S_5); end
            end
            if (p == 32) begin
                checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL bx_ready_post: got %b required 1", bus.load_ready); end
                checks++; if (seg !== S_9) begin failures++; $display("FAIL bx_seg_new: got %h required %h", seg, S_9); end
            end
            if (p == 15) begin
                bus.load_valid = 1'b1;
                bus.load_data  = 16'h9999;
                bus.load_dp    = 4'b0000;
            end else if (p == 16) begin
                bus.load_valid = 1'b0;
            end
        end
    endtask

    task automatic test_disable();
        wait_frame();
        repeat (8) @(negedge clk);
        checks++; if (digit_sel !== 2'd2) begin failures++; $display("FAIL dis_pre_digit: got %0d required 2", digit_sel); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (digit_sel !== 2'd0 || seg !== S_BLANK || dp !== 1'b1 || frame_done !== 1'b0) begin
            failures++; $display("FAIL dis_off: digit %0d seg %h dp %b fd %b required 0/7f/1/0", digit_sel, seg, dp, frame_done);
        end
        repeat (2) @(negedge clk);
        checks++; if (seg !== S_BLANK || digit_sel !== 2'd0) begin failures++; $display("FAIL dis_hold: seg %h digit %0d required 7f/0", seg, digit_sel); end
        enable = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++; if (digit_sel !== ((s < 4) ? 2'd0 : 2'd1)) begin failures++; $display("FAIL dis_restart_digit s=%0d: got %0d required %0d", s, digit_sel, (s < 4) ? 0 : 1); end
            checks++; if (seg !== S_9 || dp !== 1'b1) begin failures++; $display("FAIL dis_restart_seg s=%0d: got %h/%b required %h/1", s, seg, dp, S_9); end
        end
    endtask

    task automatic test_reset_mid();
        wait_frame();
        repeat (4) @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h2222;
        bus.load_dp    = 4'b1111;
        @(negedge clk);
        checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL rm_ready_busy: got %b required 0", bus.load_ready); end
        bus.load_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (digit_sel !== 2'd0 || seg !== S_BLANK || dp !== 1'b1 || frame_done !== 1'b0) begin
            failures++; $display("FAIL rm_async: digit %0d seg %h dp %b fd %b required 0/7f/1/0", digit_sel, seg, dp, frame_done);
        end
        checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL rm_ready: got %b required 1", bus.load_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            checks++; if (seg !== S_0 || dp !== 1'b1) begin failures++; $display("FAIL rm_seg s=%0d: got %h/%b required %h/1", s, seg, dp, S_0); end
            checks++; if (digit_sel !== 2'((s / 4) % 4)) begin failures++; $display("FAIL rm_digit s=%0d: got %0d required %0d", s, digit_sel, (s / 4) % 4); end
            checks++; if (frame_done !== (s == 16)) begin failures++; $display("FAIL rm_fd s=%0d: got %b required %b", s, frame_done, (s == 16)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan_zero();
        test_load(16'h1A8F, 4'b0100, 6, {S_1, S_A, S_8, S_F}, 4'b1011);
        test_stream();
        test_boundary_xfer();
`ifdef LEADING_ZERO_BLANK_EN
        test_load(16'h0070, 4'b0000, 0, {S_BLANK, S_BLANK, S_7, S_0}, 4'b1111);
        test_load(16'h0000, 4'b1000, 0, {S_0, S_BLANK, S_BLANK, S_0}, 4'b0111);
`else
        test_load(16'h0070, 4'b0000, 0, {S_0, S_0, S_7, S_0}, 4'b1111);
        test_load(16'h0000, 4'b1000, 0, {S_0, S_0, S_0, S_0}, 4'b0111);
`endif
        test_load(16'h9999, 4'b0000, 3, {S_9, S_9, S_9, S_9}, 4'b1111);
        test_disable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot; legal range 2..1048576.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 enable  input  1  scanning on when 1; display off when 0.
REQ-005 load_valid  input  1  a new display value is offered.
REQ-006 load_ready  output  1  the block can accept a new value.
REQ-007 load_data  input  16  four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-008 load_dp  input  4  decimal point per digit; bit n belongs to digit n; 1 means lit.
REQ-009 digit_sel  output  2  active digit index; feeds the anode decoder directly.
REQ-010 seg  output  7  segments, active-low; seg[6]=g down to seg[0]=a.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-013 The FSM SHALL have two states: OFF and SCAN. OFF goes to SCAN on the edge where enable=1. SCAN goes to OFF on the edge where enable=0, at any point in the frame.
REQ-014 In OFF:
- the prescaler and digit_sel SHALL be held at 0;
- seg SHALL be 7'h7F and dp SHALL be 1;
- frame_done SHALL be 0.
REQ-015 In SCAN, the prescaler SHALL count 0..REFRESH_DIV-1 and then wrap to 0. The cycle with count==REFRESH_DIV-1 is the "tick".
REQ-016 On each tick, digit_sel SHALL increment and wrap from 3 to 0. seg and dp SHALL update on the same edge, so the outputs never show a mismatched digit and segment pattern.
REQ-017 On a tick with digit_sel==3, frame_done SHALL be 1 for exactly one cycle. That cycle is the "frame boundary".
REQ-018 seg SHALL be the hex decode of the active nibble. Required encodings include:
- 0 = 7'b1000000
- 1 = 7'b1111001
- 8 = 7'b0000000
- A = 7'b0001000
- F = 7'b0001110
REQ-019 dp SHALL be the inverse of the active load_dp bit.
REQ-020 The value path SHALL use two registers: a pending register (value, dp, pending_valid) and an active register.
REQ-021 load_ready SHALL be the inverse of pending_valid. A transfer occurs when load_valid and load_ready are both 1; it captures load_data and load_dp into the pending register and sets pending_valid.
REQ-022 In SCAN, pending SHALL move to active only at a frame boundary, and pending_valid SHALL clear on that same edge.
REQ-023 In OFF, pending SHALL move to active on the edge after the transfer.
REQ-024 If a transfer and a frame boundary occur on the same edge with pending_valid=0, the new data SHALL go to pending only. It reaches active at the next boundary.
REQ-025 load_data SHALL be ignored when load_valid=0 or load_ready=0.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force:
- state=OFF, prescaler=0, digit_sel=0;
- seg=7'h7F, dp=1, frame_done=0;
- load_ready=1, pending_valid=0;
- active value=16'h0000, active dp=4'b0000.
REQ-027 Reset asserted mid-frame or mid-transfer SHALL discard the pending value. After release, the first active edge SHALL behave as in OFF.

Configuration
REQ-028 When macro LEADING_ZERO_BLANK_EN is defined, a digit n SHALL be blanked (seg=7'h7F) if all of the following hold:
- n>0;
- active nibbles n..3 are all zero;
- the active dp bit n is 0.
Digit 0 SHALL never be blanked.
REQ-029 When LEADING_ZERO_BLANK_EN is undefined, all four digits SHALL always be decoded, with no blanking logic present.

Verification (REFRESH_DIV=4)
REQ-030 Reset, then enable=1 with active=16'h0000 -> digit_sel steps 0,1,2,3,0 every 4 cycles; seg=7'b1000000 on all digits (macro off); frame_done pulses once per 16 cycles.
REQ-031 Load 16'h1A8F with dp=4'b0100 mid-frame -> load_ready=0 until the next frame_done; in the following frame, digits 0..3 show F, 8, A, 1, and dp=0 only while digit_sel=2.
REQ-032 Assert load_valid continuously with a new value every cycle -> exactly one transfer per frame; active updates only on frame_done edges.
REQ-033 Drop enable at digit_sel=2 -> next edge: digit_sel=0, seg=7'h7F, dp=1. Re-enable -> scanning restarts at digit 0 with prescaler 0.
REQ-034 Pulse rst_n low mid-frame with pending_valid=1 -> outputs take their reset values without waiting for a clock edge; load_ready=1; the pending value never appears on seg.
REQ-035 With LEADING_ZERO_BLANK_EN defined, load 16'h0070 -> digits 3 and 2 show 7'h7F, digit 1 shows 7, digit 0 shows 0. Then load 16'h0000 with dp=4'b1000 -> digit 3 shows 0 with dp lit; digits 2 and 1 are blank.
